// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//
// Parameterised 4-to-1 multiplexer. The data path is combinational. It also
// keeps an optional registered copy of the selected data for consumers that
// are pipelined.
//
// Parameters
//   WIDTH    width of each data input and of both data outputs (1..64)
//
// Ports
//   clk      rising-edge clock for the registered path
//   rst      synchronous active-high reset for the registered path
//   i0..i3   data inputs, selected by index {s1,s0} = 0..3
//   s0, s1   select bits; s1 is the MSB
//   en       capture enable for the registered path
//   out      combinational selected data
//   sel_oh   combinational one-hot decode of {s1,s0}
//   out_q    registered selected data
//   valid_q  high once out_q holds data captured since the last reset
// -----------------------------------------------------------------------------
module mux_4x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       sel_oh,
    output logic [WIDTH-1:0] out_q,
    output logic             valid_q
);

    logic [1:0]       sel_idx;
    logic [WIDTH-1:0] data_arr [4];
    logic [WIDTH-1:0] out_q_reg;
    logic             valid_q_reg;

    assign sel_idx = {s1, s0};

    assign data_arr[0] = i0;
    assign data_arr[1] = i1;
    assign data_arr[2] = i2;
    assign data_arr[3] = i3;

    // One decoder bit per input.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign sel_oh[gi] = (sel_idx == 2'(gi));
        end
    endgenerate

    // Combinational select. An unknown select drives zeros rather than
    // holding a stale value, so this block never infers a latch.
    always_comb begin
        out = '0;
        case (sel_idx)
            2'b00:   out = data_arr[0];
            2'b01:   out = data_arr[1];
            2'b10:   out = data_arr[2];
            2'b11:   out = data_arr[3];
            default: out = '0;
        endcase
    end

    // Registered copy. Reset takes priority over the capture enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_reg   <= '0;
            valid_q_reg <= 1'b0;
        end else if (en) begin
            out_q_reg   <= out;
            valid_q_reg <= 1'b1;
        end
    end

    assign out_q   = out_q_reg;
    assign valid_q = valid_q_reg;

endmodule

// File: tb/tb_mux_4x1.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1
//
// Bench for mux_4x1. It drives one WIDTH=1 instance and one WIDTH=8 instance.
// The first phase is a table of select vectors applied with the clock stopped.
// Hand-written sequences then cover reset, enable hold, reset priority and
// data that changes between edges. A randomized run compares the WIDTH=8
// instance against a reference model. That model indexes an array for the
// data and shifts a one for the decode. Its registered state follows the
// reset, enable and capture rules directly.
// -----------------------------------------------------------------------------
module tb_mux_4x1;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic       s0;
    logic       s1;

    logic [7:0] d8 [4];
    logic [0:0] d1 [4];

    logic [7:0] out8;
    logic [3:0] oh8;
    logic [7:0] out_q8;
    logic       valid_q8;
    logic [0:0] out1;
    logic [3:0] oh1;
    logic [0:0] out_q1;
    logic       valid_q1;

    int n_vec;
    int n_err;

    // Reference model state for the registered path of the WIDTH=8 instance.
    logic [7:0] model_q;
    logic       model_v;

    mux_4x1 #(.WIDTH(8)) u_w8 (
        .clk     (clk),
        .rst     (rst),
        .i0      (d8[0]),
        .i1      (d8[1]),
        .i2      (d8[2]),
        .i3      (d8[3]),
        .s0      (s0),
        .s1      (s1),
        .en      (en),
        .out     (out8),
        .sel_oh  (oh8),
        .out_q   (out_q8),
        .valid_q (valid_q8)
    );

    mux_4x1 #(.WIDTH(1)) u_w1 (
        .clk     (clk),
        .rst     (rst),
        .i0      (d1[0]),
        .i1      (d1[1]),
        .i2      (d1[2]),
        .i3      (d1[3]),
        .s0      (s0),
        .s1      (s1),
        .en      (en),
        .out     (out1),
        .sel_oh  (oh1),
        .out_q   (out_q1),
        .valid_q (valid_q1)
    );

    // The clock toggles only while clk_run is set.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Watchdog so that the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0] sel;
        logic [0:0] exp1;
        logic [7:0] exp8;
        logic [3:0] exp_oh;
    } vec_t;

    vec_t table_v [4];

    function automatic logic [7:0] ref_mux(input logic [1:0] s, input logic [7:0] d [4]);
        return d[s];
    endfunction

    function automatic logic [3:0] ref_oh(input logic [1:0] s);
        return 4'd1 << s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        {s1, s0} = s;
    endtask

    // Advance one rising edge and update the model with the values that were
    // present before the edge. Outputs are sampled 1 ns later.
    task automatic step();
        logic [7:0] pre;
        logic       pre_rst;
        logic       pre_en;
        pre     = ref_mux({s1, s0}, d8);
        pre_rst = rst;
        pre_en  = en;
        @(posedge clk);
        if (pre_rst) begin
            model_q = '0;
            model_v = 1'b0;
        end else if (pre_en) begin
            model_q = pre;
            model_v = 1'b1;
        end
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        en       = 1'b0;
        s0       = 1'b0;
        s1       = 1'b0;
        model_q  = '0;
        model_v  = 1'b0;

        // Phase 1: combinational sweeps with the clock stopped.
        d1[0] = 1'b0; d1[1] = 1'b1; d1[2] = 1'b1; d1[3] = 1'b0;
        d8[0] = 8'hA5; d8[1] = 8'h3C; d8[2] = 8'hFF; d8[3] = 8'h00;
        table_v[0] = '{2'b00, 1'b0, 8'hA5, 4'b0001};
        table_v[1] = '{2'b01, 1'b1, 8'h3C, 4'b0010};
        table_v[2] = '{2'b10, 1'b1, 8'hFF, 4'b0100};
        table_v[3] = '{2'b11, 1'b0, 8'h00, 4'b1000};
        for (int k = 0; k < 4; k++) begin
            set_sel(table_v[k].sel);
            #10;
            $display("vec sel=%b out1=%b out8=%h oh=%b", table_v[k].sel, out1, out8, oh8);
            chk("sweep_out1", 64'(out1), 64'(table_v[k].exp1));
            chk("sweep_oh1",  64'(oh1),  64'(table_v[k].exp_oh));
            chk("sweep_out8", 64'(out8), 64'(table_v[k].exp8));
            chk("sweep_oh8",  64'(oh8),  64'(table_v[k].exp_oh));
        end

        // Phase 2: reset with en=1 and select 01.
        clk_run = 1'b1;
        rst = 1'b1; en = 1'b1; set_sel(2'b01);
        for (int k = 0; k < 2; k++) begin
            step();
            $display("rst cyc%0d out_q=%h valid_q=%b out=%h", k, out_q8, valid_q8, out8);
            chk("rst_out_q",   64'(out_q8),   64'h0);
            chk("rst_valid_q", 64'(valid_q8), 64'h0);
            chk("rst_out",     64'(out8),     64'h3C);
        end
        rst = 1'b0;
        step();
        $display("rst release out_q=%h valid_q=%b", out_q8, valid_q8);
        chk("rel_out_q",   64'(out_q8),   64'h3C);
        chk("rel_valid_q", 64'(valid_q8), 64'h1);

        // Phase 3: enable hold.
        set_sel(2'b11); d8[3] = 8'h5A;
        step();
        chk("cap3_out_q", 64'(out_q8), 64'h5A);
        en = 1'b0; set_sel(2'b00);
        for (int k = 0; k < 3; k++) begin
            step();
            $display("hold cyc%0d out_q=%h out=%h", k, out_q8, out8);
            chk("hold_out_q", 64'(out_q8), 64'h5A);
            chk("hold_out",   64'(out8),   64'hA5);
        end
        en = 1'b1;
        step();
        chk("reen_out_q", 64'(out_q8), 64'hA5);

        // Phase 4: reset has priority over en.
        rst = 1'b1; en = 1'b1; set_sel(2'b10); d8[2] = 8'h01;
        step();
        $display("prio out_q=%h valid_q=%b", out_q8, valid_q8);
        chk("prio_out_q",   64'(out_q8),   64'h0);
        chk("prio_valid_q", 64'(valid_q8), 64'h0);
        rst = 1'b0;

        // Phase 5: live data change between edges.
        set_sel(2'b01); d8[1] = 8'h00;
        step();
        chk("live_cap0", 64'(out_q8), 64'h00);
        d8[1] = 8'h01; #1;
        chk("live_out1",  64'(out8),   64'h01);
        chk("live_q_hold", 64'(out_q8), 64'h00);
        d8[1] = 8'h00; #1;
        chk("live_out0",  64'(out8),   64'h00);
        d8[1] = 8'h01; #1;
        step();
        $display("live out_q=%h", out_q8);
        chk("live_cap1", 64'(out_q8), 64'h01);

        // Phase 6: randomized run against the reference model.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) d8[j] = 8'($urandom);
            set_sel(2'($urandom));
            en  = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            #1;
            chk("rnd_out", 64'(out8), 64'(ref_mux({s1, s0}, d8)));
            chk("rnd_oh",  64'(oh8),  64'(ref_oh({s1, s0})));
            step();
            $display("rnd %0d sel=%b en=%b rst=%b out_q=%h valid_q=%b", k, {s1, s0}, en, rst, out_q8, valid_q8);
            chk("rnd_out_q",   64'(out_q8),   64'(model_q));
            chk("rnd_valid_q", 64'(valid_q8), 64'(model_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
